// File: rtl/fnd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : fnd_scan_driver
// Description : Captures an MM:SS value, converts it to BCD and time-
//               multiplexes it onto a 4-digit common-anode 7-segment display
//               with an anti-ghost blank cycle per slot, a blinking
//               separator dot and optional leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic       i_load,
  output logic [3:0] o_com,
  output logic [6:0] o_seg,
  output logic       o_dp
);

  localparam int            CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [5:0]    VAL_MAX  = 6'd59;
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;
  localparam logic [3:0]    COM_OFF  = 4'b1111;

  logic [CW-1:0] cnt;
  logic [1:0]    ptr;
  logic [5:0]    min_r;
  logic [5:0]    sec_r;

  logic [3:0]    com_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic [3:0]    min_tens, min_ones, sec_tens, sec_ones;
  logic [3:0]    digit;
  logic [3:0]    com_d;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic          wrap;

  // Binary 0..63 to two BCD digits; inputs are already limited to 0..59.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] t;
    logic [5:0] o;
    t = v / 6'd10;
    o = v - (t * 6'd10);
    return {t[3:0], o[3:0]};
  endfunction

  // Active-low {g,f,e,d,c,b,a} decode; non-decimal codes show nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign {min_tens, min_ones} = to_bcd(min_r);
  assign {sec_tens, sec_ones} = to_bcd(sec_r);
  assign wrap = (cnt == CNT_MAX);

  // Capture register: saturate out-of-range values to 59, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_r <= '0;
      sec_r <= '0;
    end else if (i_load) begin
      min_r <= (i_min > VAL_MAX) ? VAL_MAX : i_min;
      sec_r <= (i_sec > VAL_MAX) ? VAL_MAX : i_sec;
    end
  end

  // Slot counter and digit pointer; the pointer advances on the slot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ptr <= '0;
    end else if (wrap) begin
      cnt <= '0;
      ptr <= ptr + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Next display values from the current scan position and captured value.
  always_comb begin
    com_d = COM_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    digit = 4'd0;
    case (ptr)
      2'd0:    digit = sec_ones;
      2'd1:    digit = sec_tens;
      2'd2:    digit = min_ones;
      default: digit = min_tens;
    endcase
    // The first cycle of every slot stays dark so the previous digit's
    // segments never bleed into the next anode.
    if (cnt != '0) begin
      com_d = ~(4'b0001 << ptr);
      seg_d = seg_decode(digit);
      if (BLANK_LZ && (ptr == 2'd3) && (min_tens == 4'd0)) begin
        seg_d = SEG_OFF;
      end
      dp_d = ~((ptr == 2'd2) && !sec_r[0]);
    end
  end

  // Output registers: one cycle behind the scan/capture state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      com_q <= COM_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      com_q <= com_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign o_com = com_q;
  assign o_seg = seg_q;
  assign o_dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_fnd_scan_driver
// Description : Directed, table-driven bench for fnd_scan_driver with
//               SCAN_DIV=4; one instance without and one with leading-zero
//               blanking share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_driver;

  localparam logic [6:0] BLK = 7'b1111111;

  typedef struct {
    logic       load;
    logic [5:0] mn;
    logic [5:0] sc;
    logic [3:0] com;
    logic [6:0] seg;
    logic [6:0] seg_lz;
    logic       dp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] i_min;
  logic [5:0] i_sec;
  logic       i_load;
  logic [3:0] com0, com1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  fnd_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_min(i_min), .i_sec(i_sec), .i_load(i_load),
    .o_com(com0), .o_seg(seg0), .o_dp(dp0)
  );

  fnd_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i_min(i_min), .i_sec(i_sec), .i_load(i_load),
    .o_com(com1), .o_seg(seg1), .o_dp(dp1)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act[6:0], exp[6:0], $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] com,
                         input logic [6:0] seg, input logic [6:0] seg_lz,
                         input logic dp);
    chk({tag, " com"},    int'(com0), int'(com));
    chk({tag, " seg"},    int'(seg0), int'(seg));
    chk({tag, " dp"},     int'(dp0),  int'(dp));
    chk({tag, " lz com"}, int'(com1), int'(com));
    chk({tag, " lz seg"}, int'(seg1), int'(seg_lz));
    chk({tag, " lz dp"},  int'(dp1),  int'(dp));
  endtask

  task automatic add(input logic ld, input logic [5:0] mn, input logic [5:0] sc,
                     input logic [3:0] com, input logic [6:0] seg,
                     input logic [6:0] seg_lz, input logic dp);
    vec_t v;
    v.load = ld; v.mn = mn; v.sc = sc;
    v.com = com; v.seg = seg; v.seg_lz = seg_lz; v.dp = dp;
    vq.push_back(v);
  endtask

  // Blank cycle with unloaded (ignored) input changes.
  task automatic blank();
    add(1'b0, 6'd45, 6'd17, 4'b1111, BLK, BLK, 1'b1);
  endtask

  // Load on a blank cycle.
  task automatic load_blank(input logic [5:0] mn, input logic [5:0] sc);
    add(1'b1, mn, sc, 4'b1111, BLK, BLK, 1'b1);
  endtask

  // Three driven cycles of one digit slot.
  task automatic slot(input logic [3:0] com, input logic [6:0] seg,
                      input logic [6:0] seg_lz, input logic dp);
    for (int i = 0; i < 3; i++) add(1'b0, 6'd45, 6'd17, com, seg, seg_lz, dp);
  endtask

  initial begin
    // 12:34
    load_blank(6'd12, 6'd34);
    slot(4'b1110, 7'b0011001, 7'b0011001, 1'b1); blank();
    slot(4'b1101, 7'b0110000, 7'b0110000, 1'b1); blank();
    slot(4'b1011, 7'b0100100, 7'b0100100, 1'b0); blank();
    slot(4'b0111, 7'b1111001, 7'b1111001, 1'b1);
    // 63:60 saturates to 59:59
    load_blank(6'd63, 6'd60);
    slot(4'b1110, 7'b0010000, 7'b0010000, 1'b1); blank();
    slot(4'b1101, 7'b0010010, 7'b0010010, 1'b1); blank();
    slot(4'b1011, 7'b0010000, 7'b0010000, 1'b1); blank();
    slot(4'b0111, 7'b0010010, 7'b0010010, 1'b1);
    // 05:00, leading zero only blanked on the BLANK_LZ instance
    load_blank(6'd5, 6'd0);
    slot(4'b1110, 7'b1000000, 7'b1000000, 1'b1); blank();
    slot(4'b1101, 7'b1000000, 7'b1000000, 1'b1); blank();
    slot(4'b1011, 7'b0010010, 7'b0010010, 1'b0); blank();
    slot(4'b0111, 7'b1000000, BLK,        1'b1);
    // Inputs change without load: display holds 05:00
    add(1'b0, 6'd33, 6'd44, 4'b1111, BLK, BLK, 1'b1);
    add(1'b0, 6'd33, 6'd44, 4'b1110, 7'b1000000, 7'b1000000, 1'b1);
    // Load 00:07 mid ptr-0 slot: old digit on the capture edge, new one next
    add(1'b1, 6'd0, 6'd7, 4'b1110, 7'b1000000, 7'b1000000, 1'b1);
    // Load 00:28 on the wrap edge: new ptr and new value land together
    add(1'b1, 6'd0, 6'd28, 4'b1110, 7'b1111000, 7'b1111000, 1'b1);
    blank();
    slot(4'b1101, 7'b0100100, 7'b0100100, 1'b1); blank();
    add(1'b0, 6'd45, 6'd17, 4'b1011, 7'b1000000, 7'b1000000, 1'b0);

    // Reset held for three edges.
    rst = 1'b1; i_load = 1'b0; i_min = '0; i_sec = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_all("reset", 4'b1111, BLK, BLK, 1'b1);
    end
    rst = 1'b0;

    // Table: inputs set before each edge, outputs checked #1 after it.
    for (int k = 0; k < vq.size(); k++) begin
      i_load = vq[k].load; i_min = vq[k].mn; i_sec = vq[k].sc;
      @(posedge clk); #1;
      i_load = 1'b0;
      chk_all($sformatf("vec%0d", k), vq[k].com, vq[k].seg, vq[k].seg_lz, vq[k].dp);
    end

    // Asynchronous reset mid ptr-2 slot: outputs must drop before next edge.
    #2 rst = 1'b1;
    #1 chk_all("async rst", 4'b1111, BLK, BLK, 1'b1);
    @(posedge clk); #1;
    chk_all("rst held", 4'b1111, BLK, BLK, 1'b1);
    rst = 1'b0;

    // One frame of 00:00 starting from ptr 0 with a blank first cycle.
    for (int k = 0; k < 16; k++) begin
      logic [3:0] ec;
      logic [6:0] es, esl;
      logic       ed;
      int         p;
      p = k / 4;
      if ((k % 4) == 0) begin
        ec = 4'b1111; es = BLK; esl = BLK; ed = 1'b1;
      end else begin
        ec  = ~(4'b0001 << p);
        es  = 7'b1000000;
        esl = (p == 3) ? BLK : 7'b1000000;
        ed  = (p == 2) ? 1'b0 : 1'b1;
      end
      @(posedge clk); #1;
      chk_all($sformatf("post-rst%0d", k), ec, es, esl, ed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fnd_scan_driver.md
Name: fnd_scan_driver

Overview:
Display stage downstream of the seconds/minutes counters.
- Captures a minutes value and a seconds value (each 0..59), converts each to two BCD digits, and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Provides per-digit scan timing, an anti-ghost blank cycle, a blinking separator dot, and optional leading-zero blanking.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (1 kHz slot rate at 50 MHz); legal range >= 2
BLANK_LZ, 0, 1 = blank the minutes-tens digit when it is 0

Ports:
clk     input   1  system clock, rising edge
rst     input   1  reset, asynchronous, active-high
i_min   input   6  minutes value, binary
i_sec   input   6  seconds value, binary
i_load  input   1  1-cycle capture strobe for i_min/i_sec
o_com   output  4  digit enables, active-low, one-hot-low; bit0 = rightmost digit
o_seg   output  7  segments {g,f,e,d,c,b,a}, active-low
o_dp    output  1  decimal point, active-low

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
  - While rst=1: cnt=0, ptr=0, min_r=0, sec_r=0, o_com=4'b1111, o_seg=7'b1111111, o_dp=1.
  - Outputs go inactive immediately on rst assertion; no clock edge is needed.
- Capture: on a clock edge with i_load=1, min_r <= min(i_min, 59) and sec_r <= min(i_sec, 59).
  - Values above 59 saturate to 59.
  - With i_load=0, min_r and sec_r hold regardless of input changes.
- BCD conversion: tens = v/10, ones = v%10, computed from min_r and sec_r. Combinational logic is allowed; results are 4 bits each.
- Slot counter cnt, range 0..SCAN_DIV-1: increments every cycle and wraps to 0 when cnt == SCAN_DIV-1.
- Digit pointer ptr (2 bits): increments on the edge where cnt wraps; 3 wraps to 0.
  - ptr 0 = sec ones (o_com=1110)
  - ptr 1 = sec tens (1101)
  - ptr 2 = min ones (1011)
  - ptr 3 = min tens (0111)
- Outputs are registered every cycle from the current cnt, ptr, min_r and sec_r, so they lag those registers by exactly 1 cycle.
  - If cnt==0: o_com=1111, o_seg=1111111, o_dp=1 (anti-ghost blank).
  - Otherwise: o_com selects ptr; o_seg is the decoded digit.
- Slot and frame timing: each slot is 1 blank cycle followed by SCAN_DIV-1 driven cycles. A frame is 4*SCAN_DIV cycles.
  - After reset release, the first output update is blank and the first driven digit is ptr 0.
- Segment codes (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10..15 cannot occur; decode them as 1111111.
- Decimal point: o_dp=0 only when ptr==2, cnt!=0 and sec_r[0]==0. This blinks the separator at half the seconds rate. Otherwise o_dp=1.
- Leading-zero blanking: if BLANK_LZ=1, ptr==3 and min tens==0, then o_seg=1111111 while o_com stays 0111.
- Simultaneous i_load and slot wrap: both take effect on the same edge. The next output update uses the new ptr and the new captured value.
- Reset mid-frame: scan restarts from ptr 0 and the captured value returns to 00:00.

Test Plan:
(All scenarios use SCAN_DIV=4.)
1. rst=1 for 3 cycles, then released → o_com=1111, o_seg=1111111, o_dp=1 throughout reset and on the first edge after release; the next edge gives o_com=1110, o_seg=1000000.
2. Load min=12, sec=34, observe one frame → per slot: 1 cycle of 1111, then 3 cycles of:
   - 1110 / 0011001
   - 1101 / 0110000
   - 1011 / 0100100 with o_dp=0
   - 0111 / 1111001
3. Load min=63, sec=60 → displays 59:59. Digit codes are 0010000, 0010010, 0010000, 0010010. o_dp=1 on ptr 2 (59 is odd).
4. BLANK_LZ=1, load min=5, sec=0 → ptr 3 slot gives o_com=0111, o_seg=1111111; ptr 2 gives 0010010 with o_dp=0. With BLANK_LZ=0, ptr 3 gives 1000000.
5. Change i_min/i_sec with i_load=0 mid-frame → display unchanged. Pulse i_load during the ptr 0 slot → o_seg changes exactly 1 cycle after the capture edge.
6. Assert rst asynchronously (between edges) mid-slot of ptr 2 → outputs go off before the next edge. After release, ptr 0 is driven first with 00:00 (o_seg=1000000 on all digits).
